idu_inbuf: RTL and testbench
============================

IDU_INBUF -- requirements
Module: idu_inbuf

Interface
REQ-001 The block SHALL have one parameter, NOP_INS, default 32'h00000013, giving the instruction driven on o_idu_ins while no entry is valid.
REQ-002 The block SHALL have input i_clk, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have input i_rst_n, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have input i_pre_valid, 1 bit: the upstream fetch stage offers a pc/ins pair.
REQ-005 The block SHALL have output o_pre_ready, 1 bit: this block can accept the offered pair.
REQ-006 The block SHALL have input i_ifu_pc, `CPU_WIDTH bits: the fetched pc.
REQ-007 The block SHALL have input i_ifu_ins, `INS_WIDTH bits: the fetched instruction.
REQ-008 The block SHALL have output o_post_valid, 1 bit: the head entry is valid toward decode.
REQ-009 The block SHALL have input i_post_ready, 1 bit: the decode stage consumes the head entry.
REQ-010 The block SHALL have input i_flush, 1 bit: redirect; all held entries are discarded.
REQ-011 The block SHALL have output o_idu_pc, `CPU_WIDTH bits: the pc of the head entry.
REQ-012 The block SHALL have output o_idu_ins, `INS_WIDTH bits: the instruction of the head entry, or NOP_INS when no entry is valid.

Function
REQ-013 An input transfer SHALL occur on a cycle where i_pre_valid & o_pre_ready is 1, and an output transfer SHALL occur on a cycle where o_post_valid & i_post_ready is 1.
REQ-014 Entries SHALL leave the block in the order they were accepted, with no duplication and no loss except on flush.
REQ-015 Latency SHALL be one cycle: a pair accepted at edge N SHALL be presented at o_post_valid/o_idu_* after edge N when the block was empty.
REQ-016 The head entry SHALL hold stable until it is consumed.
REQ-017 o_idu_pc and o_idu_ins SHALL come directly from registers, with no combinational path from i_ifu_*.
REQ-018 While i_flush=1, o_pre_ready SHALL be 0.
REQ-019 The edge on which i_flush=1 SHALL clear all valid bits, and that cycle's input SHALL be discarded.
REQ-020 When i_flush=1 coincides with an output transfer, the transfer SHALL count as consumed, and no entry SHALL remain afterwards.
REQ-021 With an empty block, a simultaneous input offer and i_post_ready SHALL capture the entry; it SHALL NOT pass through in the same cycle.

Reset
REQ-022 While i_rst_n=0, all valid bits SHALL be 0, stored pc SHALL be 0, and stored ins SHALL be NOP_INS.
REQ-023 During reset, o_post_valid SHALL be 0 and o_pre_ready SHALL be 0.
REQ-024 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-025 After i_rst_n deasserts, o_pre_ready SHALL be 1 on the first cycle.

Configuration
REQ-026 The macro IDU_INBUF_SKID_EN SHALL select between two buffering schemes.
REQ-027 Without IDU_INBUF_SKID_EN, the block SHALL have a single entry, with o_pre_ready = ~i_flush & (~vld | i_post_ready), which is combinational from i_post_ready.
REQ-028 With IDU_INBUF_SKID_EN, the block SHALL have two entries (main and skid), with o_pre_ready = ~i_flush & ~skid_vld, which has no combinational path from i_post_ready.
REQ-029 In skid mode, an input accepted while main is valid and not being consumed SHALL go to skid.
REQ-030 In skid mode, when main is consumed, skid SHALL move to main on that edge; if an input is accepted on the same edge, it SHALL land in skid only if skid was occupied, and otherwise in main.
REQ-031 In skid mode, a full block (both valid) SHALL present o_pre_ready=0 until one entry drains.
REQ-032 Both builds SHALL sustain one transfer per cycle when i_post_ready is held at 1.

Structure
REQ-033 The package cpu_pkg SHALL hold the typedef ifu2idu_t {pc, ins}, and each entry register SHALL store one ifu2idu_t.
REQ-034 The `CPU_WIDTH and `INS_WIDTH macros SHALL come from the shared define file; the NOP constant SHALL live in cpu_pkg.
REQ-035 Every state register SHALL be an instance of the existing stl_reg (WIDTH, RESET_VAL, i_wen); no other sub-module SHALL be used.

Verification
REQ-036 Reset: release i_rst_n with i_pre_valid=0, and check o_post_valid=0, o_idu_ins=32'h00000013 and o_pre_ready=1.
REQ-037 Stream: send pc 0x80000000, 0x80000004, 0x80000008 with i_post_ready=1, and check each appears one cycle later in order, at one per cycle.
REQ-038 Backpressure: hold i_post_ready=0 and offer 3 pairs.
- Single build: check that only 1 pair is accepted and o_pre_ready=0.
- Skid build: check that 2 pairs are accepted and o_pre_ready=0.
- Then raise i_post_ready and check both builds drain in order.
REQ-039 Flush: with two entries held (skid build), pulse i_flush together with i_pre_valid (pc 0x80000100), and check o_post_valid=0 next cycle and that pc 0x80000100 is never output.
REQ-040 Simultaneous: with the skid build full, set i_post_ready=1 and i_pre_valid=1, and check that old skid moves to head, o_pre_ready returns to 1 the next cycle, and order is preserved.
REQ-041 Async reset: assert i_rst_n low mid-stream between clock edges, and check o_post_valid drops to 0 before the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU defines and types: datapath widths (CPU_WIDTH, INS_WIDTH), the
// fetch->decode entry, and the NOP encoding presented while decode has nothing.
// Widths default to RV32 and may be overridden on the command line.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef INS_WIDTH
`define INS_WIDTH 32
`endif

package cpu_pkg;

  localparam int CPU_W = `CPU_WIDTH;
  localparam int INS_W = `INS_WIDTH;

  // addi x0, x0, 0
  localparam logic [INS_W-1:0] INS_NOP = INS_W'(32'h00000013);

  // One fetched pair travelling from IFU to IDU.
  typedef struct packed {
    logic [CPU_W-1:0] pc;
    logic [INS_W-1:0] ins;
  } ifu2idu_t;

endpackage

// File: rtl/stl_reg.sv
// Generic state register with write enable and asynchronous active-low reset.
// Latency: one cycle from i_din/i_wen to o_dout.
// Backpressure: none; the caller decides when to write via i_wen.
module stl_reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wen,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  // Load on write enable; reset value applies immediately on reset assertion.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dout <= RESET_VAL;
    end else if (i_wen) begin
      o_dout <= i_din;
    end
  end

endmodule

// File: rtl/idu_inbuf.sv
// Fetch->decode input buffer holding pc/ins pairs until decode consumes them, in order.
// Latency: one cycle from acceptance to presentation when empty; outputs are registered.
// Backpressure: default single entry, o_pre_ready follows i_post_ready combinationally;
//   with IDU_INBUF_SKID_EN a main+skid pair, o_pre_ready depends only on state and i_flush.
module idu_inbuf
  import cpu_pkg::*;
#(
  parameter logic [`INS_WIDTH-1:0] NOP_INS = INS_NOP
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_pre_valid,
  output logic                  o_pre_ready,
  input  logic [`CPU_WIDTH-1:0] i_ifu_pc,
  input  logic [`INS_WIDTH-1:0] i_ifu_ins,
  output logic                  o_post_valid,
  input  logic                  i_post_ready,
  input  logic                  i_flush,
  output logic [`CPU_WIDTH-1:0] o_idu_pc,
  output logic [`INS_WIDTH-1:0] o_idu_ins
);

  // Stored entries come out of reset as pc=0 with a NOP instruction.
  localparam ifu2idu_t ENT_RST = '{pc: '0, ins: NOP_INS};

  ifu2idu_t in_ent;
  ifu2idu_t head;
  logic     head_vld;
  logic     in_xfer;
  logic     out_xfer;

  assign in_ent = '{pc: i_ifu_pc, ins: i_ifu_ins};

`ifndef IDU_INBUF_SKID_EN

  // ---------------------------------------------------------------------------
  // Single-entry buffer: refill on the same edge the entry is consumed.
  // ---------------------------------------------------------------------------
  logic     vld;
  logic     vld_nxt;
  ifu2idu_t ent;

  // Ready is gated by reset so nothing is offered acceptance while held in reset.
  assign o_pre_ready = i_rst_n & ~i_flush & (~vld | i_post_ready);
  assign in_xfer     = i_pre_valid & o_pre_ready;
  assign out_xfer    = vld & i_post_ready;

  // Occupancy: flush empties, a new pair fills, a consume without refill empties.
  always_comb begin
    vld_nxt = vld;
    if (i_flush) begin
      vld_nxt = 1'b0;
    end else if (in_xfer) begin
      vld_nxt = 1'b1;
    end else if (out_xfer) begin
      vld_nxt = 1'b0;
    end
  end

  stl_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_vld (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wen   (1'b1),
    .i_din   (vld_nxt),
    .o_dout  (vld)
  );

  stl_reg #(.WIDTH($bits(ifu2idu_t)), .RESET_VAL(ENT_RST)) u_ent (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wen   (in_xfer),
    .i_din   (in_ent),
    .o_dout  (ent)
  );

  assign head     = ent;
  assign head_vld = vld;

`else

  // ---------------------------------------------------------------------------
  // Main + skid buffer: skid absorbs the one pair that arrives while main is
  // stalled, so upstream ready never depends on this cycle's i_post_ready.
  // ---------------------------------------------------------------------------
  logic     main_vld;
  logic     main_vld_nxt;
  logic     skid_vld;
  logic     skid_vld_nxt;
  ifu2idu_t main_ent;
  ifu2idu_t skid_ent;
  ifu2idu_t main_din;
  logic     main_wen;
  logic     skid_wen;
  logic     skid_to_main;
  logic     in_to_main;
  logic     in_to_skid;

  assign o_pre_ready = i_rst_n & ~i_flush & ~skid_vld;
  assign in_xfer     = i_pre_valid & o_pre_ready;
  assign out_xfer    = main_vld & i_post_ready;

  // Routing and occupancy: on consume skid refills main; a new pair goes to main
  // when main is free or freeing with skid empty, otherwise it parks in skid.
  always_comb begin
    skid_to_main = out_xfer & skid_vld;
    in_to_main   = in_xfer & (~main_vld | (out_xfer & ~skid_vld));
    in_to_skid   = in_xfer & ~in_to_main;
    main_vld_nxt = main_vld;
    skid_vld_nxt = skid_vld;
    if (i_flush) begin
      main_vld_nxt = 1'b0;
      skid_vld_nxt = 1'b0;
    end else begin
      if (skid_to_main) begin
        skid_vld_nxt = 1'b0;
      end else if (in_to_skid) begin
        skid_vld_nxt = 1'b1;
      end
      if (in_to_main | skid_to_main) begin
        main_vld_nxt = 1'b1;
      end else if (out_xfer) begin
        main_vld_nxt = 1'b0;
      end
    end
  end

  assign main_wen = ~i_flush & (in_to_main | skid_to_main);
  assign main_din = skid_to_main ? skid_ent : in_ent;
  assign skid_wen = ~i_flush & in_to_skid;

  stl_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_main_vld (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wen   (1'b1),
    .i_din   (main_vld_nxt),
    .o_dout  (main_vld)
  );

  stl_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_skid_vld (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wen   (1'b1),
    .i_din   (skid_vld_nxt),
    .o_dout  (skid_vld)
  );

  stl_reg #(.WIDTH($bits(ifu2idu_t)), .RESET_VAL(ENT_RST)) u_main_ent (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wen   (main_wen),
    .i_din   (main_din),
    .o_dout  (main_ent)
  );

  stl_reg #(.WIDTH($bits(ifu2idu_t)), .RESET_VAL(ENT_RST)) u_skid_ent (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wen   (skid_wen),
    .i_din   (in_ent),
    .o_dout  (skid_ent)
  );

  // Skid is only ever occupied behind a valid main entry.
  assert property (@(posedge i_clk) disable iff (!i_rst_n) skid_vld |-> main_vld);

  assign head     = main_ent;
  assign head_vld = main_vld;

`endif

  // Head entry straight from the entry register; NOP fills the bubble when empty.
  assign o_post_valid = head_vld;
  assign o_idu_pc     = head.pc;
  assign o_idu_ins    = head_vld ? head.ins : NOP_INS;

  // A redirect must never be accompanied by an acceptance.
  assert property (@(posedge i_clk) disable iff (!i_rst_n) i_flush |-> !o_pre_ready);

endmodule

// File: tb/tb_idu_inbuf.sv
// Scoreboard bench for idu_inbuf: an in-order queue of accepted pairs with a
// capacity-based acceptance rule; a negedge monitor checks every presented output.
// Works for both the single-entry and IDU_INBUF_SKID_EN builds.
module tb_idu_inbuf;
  import cpu_pkg::*;

`ifdef IDU_INBUF_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  localparam logic [INS_W-1:0] NOP = 32'h00000013;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_pre_valid;
  logic             o_pre_ready;
  logic [CPU_W-1:0] i_ifu_pc;
  logic [INS_W-1:0] i_ifu_ins;
  logic             o_post_valid;
  logic             i_post_ready;
  logic             i_flush;
  logic [CPU_W-1:0] o_idu_pc;
  logic [INS_W-1:0] o_idu_ins;

  idu_inbuf dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_pre_valid  (i_pre_valid),
    .o_pre_ready  (o_pre_ready),
    .i_ifu_pc     (i_ifu_pc),
    .i_ifu_ins    (i_ifu_ins),
    .o_post_valid (o_post_valid),
    .i_post_ready (i_post_ready),
    .i_flush      (i_flush),
    .o_idu_pc     (o_idu_pc),
    .o_idu_ins    (o_idu_ins)
  );

  always #5 i_clk = ~i_clk;

  ifu2idu_t sb[$];
  int       tests;
  int       fails;
  int       dut_acc;
  bit       mon_en;
  bit       exp_rdy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A pair is accepted when not flushing and the buffer has room, where a full
  // single-entry buffer also has room if its entry leaves this cycle.
  function automatic bit model_ready(input bit fl, input bit pr);
    return !fl && ((sb.size() < CAP) || (CAP == 1 && pr));
  endfunction

  // Called just after a rising edge: apply one cycle of stimulus and record
  // the expected acceptance once the monitor has seen this cycle.
  task automatic drive(input bit pv, input bit pr, input bit fl,
                       input logic [CPU_W-1:0] pc, input logic [INS_W-1:0] ins);
    bit acc;
    i_pre_valid  = pv;
    i_post_ready = pr;
    i_flush      = fl;
    i_ifu_pc     = pc;
    i_ifu_ins    = ins;
    exp_rdy      = model_ready(fl, pr);
    acc          = pv && exp_rdy;
    @(negedge i_clk);
    #1;
    if (acc) sb.push_back('{pc: pc, ins: ins});
    @(posedge i_clk);
    #1;
  endtask

  // Monitor: compare the presented head against the scoreboard, then retire it.
  always @(negedge i_clk) begin
    if (mon_en) begin
      chk("pre_ready", 64'(o_pre_ready), 64'(exp_rdy));
      chk("post_valid", 64'(o_post_valid), 64'(sb.size() != 0));
      if (i_pre_valid && o_pre_ready) dut_acc++;
      if (sb.size() != 0) begin
        chk("head_pc", 64'(o_idu_pc), 64'(sb[0].pc));
        chk("head_ins", 64'(o_idu_ins), 64'(sb[0].ins));
        if (i_post_ready) void'(sb.pop_front());
      end else begin
        chk("idle_ins", 64'(o_idu_ins), 64'(NOP));
      end
      if (i_flush) sb.delete();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    tests = 0; fails = 0; dut_acc = 0; mon_en = 1'b0; exp_rdy = 1'b0;
    i_rst_n = 1'b0; i_pre_valid = 1'b0; i_post_ready = 1'b0; i_flush = 1'b0;
    i_ifu_pc = '0; i_ifu_ins = '0;

    // Reset state
    repeat (3) @(posedge i_clk);
    #2;
    chk("rst_pre_ready", 64'(o_pre_ready), 64'd0);
    chk("rst_post_valid", 64'(o_post_valid), 64'd0);
    chk("rst_ins", 64'(o_idu_ins), 64'(NOP));
    chk("rst_pc", 64'(o_idu_pc), 64'd0);
    i_rst_n = 1'b1;
    #1;
    chk("rel_pre_ready", 64'(o_pre_ready), 64'd1);
    chk("rel_post_valid", 64'(o_post_valid), 64'd0);
    chk("rel_ins", 64'(o_idu_ins), 64'h13);
    @(posedge i_clk);
    #1;
    mon_en = 1'b1;

    // Stream at full rate
    for (int k = 0; k < 3; k++)
      drive(1'b1, 1'b1, 1'b0, 32'h80000000 + 32'(4 * k), 32'h00100093 + 32'(k << 20));
    repeat (2) drive(1'b0, 1'b1, 1'b0, '0, '0);

    // Backpressure: three offers while decode stalls
    a0 = dut_acc;
    for (int k = 0; k < 3; k++)
      drive(1'b1, 1'b0, 1'b0, 32'h80000010 + 32'(4 * k), $urandom);
    chk("bp_accepted", 64'(dut_acc - a0), 64'(CAP));
    chk("bp_pre_ready", 64'(o_pre_ready), 64'd0);
    repeat (3) drive(1'b0, 1'b1, 1'b0, '0, '0);

    // Flush with the buffer full and a pair offered
    drive(1'b1, 1'b0, 1'b0, 32'h80000020, $urandom);
    drive(1'b1, 1'b0, 1'b0, 32'h80000024, $urandom);
    drive(1'b1, 1'b0, 1'b1, 32'h80000100, $urandom);
    chk("flush_valid", 64'(o_post_valid), 64'd0);
    repeat (3) drive(1'b0, 1'b1, 1'b0, '0, '0);

    // Flush coinciding with an output transfer
    drive(1'b1, 1'b0, 1'b0, 32'h80000040, $urandom);
    drive(1'b0, 1'b1, 1'b1, '0, '0);
    chk("flush_xfer_valid", 64'(o_post_valid), 64'd0);

    // Full buffer, then consume and offer on the same cycles
    drive(1'b1, 1'b0, 1'b0, 32'h80000050, $urandom);
    drive(1'b1, 1'b0, 1'b0, 32'h80000054, $urandom);
    drive(1'b1, 1'b1, 1'b0, 32'h80000058, $urandom);
    drive(1'b1, 1'b1, 1'b0, 32'h8000005c, $urandom);
    repeat (3) drive(1'b0, 1'b1, 1'b0, '0, '0);

    // Random traffic
    for (int n = 0; n < 400; n++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
            $urandom, $urandom);

    // Asynchronous reset between edges with entries held
    drive(1'b1, 1'b0, 1'b0, 32'h80000200, $urandom);
    drive(1'b1, 1'b0, 1'b0, 32'h80000204, $urandom);
    mon_en = 1'b0;
    i_pre_valid = 1'b1;
    i_post_ready = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_post_valid", 64'(o_post_valid), 64'd0);
    chk("arst_pre_ready", 64'(o_pre_ready), 64'd0);
    chk("arst_ins", 64'(o_idu_ins), 64'(NOP));
    sb.delete();
    repeat (2) @(posedge i_clk);
    #1;
    i_pre_valid = 1'b0;
    i_rst_n = 1'b1;
    #1;
    chk("arst_rel_pre_ready", 64'(o_pre_ready), 64'd1);
    @(posedge i_clk);
    #1;
    mon_en = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h80000300, $urandom);

    // Bounded drain
    for (int n = 0; n < 8 && sb.size() != 0; n++)
      drive(1'b0, 1'b1, 1'b0, '0, '0);
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    chk("final_valid", 64'(o_post_valid), 64'd0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
